// File: rtl/mtx_seq_pkg.sv
// mtx_seq_pkg: shared types and helpers for the multi-channel phase sequencer.
//   state_e   : sequencer FSM states (IDLE, RUN, STOP)
//   ch_width  : channel-index width, max(1, clog2(NCH))
//   LFSR_*    : seed/taps for the optional phase dither (MTX_PHASE_DITHER_EN)
package mtx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback is the
  // XOR of bits 0,2,3,5, shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int ch_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/mtx_phase_acc.sv
// mtx_phase_acc: base / increment / symbol-start phase accumulators.
//   clk_i, aresetn_i, srst_i : clock, async active-low reset, sync clear
//   load_i       : frame (re)start, load start phase/increment
//   samp_adv_i   : next sample within a symbol (base += inc)
//   symb_adv_i   : next symbol within a frame (shift start, grow inc)
//   frame_adv_i  : frame wrap, reload start phase/increment
//   start_ph_i, start_inc_i, dph_inc_i, nph_shift_i : phase config
//   base_nxt_o   : next-cycle base phase (feeds the output register)
module mtx_phase_acc #(
  parameter int PW = 24
) (
  input  logic          clk_i,
  input  logic          aresetn_i,
  input  logic          srst_i,
  input  logic          load_i,
  input  logic          samp_adv_i,
  input  logic          symb_adv_i,
  input  logic          frame_adv_i,
  input  logic [PW-1:0] start_ph_i,
  input  logic [PW-1:0] start_inc_i,
  input  logic [PW-1:0] dph_inc_i,
  input  logic [PW-1:0] nph_shift_i,
  output logic [PW-1:0] base_nxt_o
);

  logic [PW-1:0] base_q, base_d;
  logic [PW-1:0] inc_q, inc_d;
  logic [PW-1:0] sstart_q, sstart_d;

  always_comb begin
    base_d   = base_q;
    inc_d    = inc_q;
    sstart_d = sstart_q;
    if (load_i || frame_adv_i) begin
      base_d   = start_ph_i;
      sstart_d = start_ph_i;
      inc_d    = start_inc_i;
    end else if (symb_adv_i) begin
      // A new symbol starts exactly on its (shifted) start phase.
      sstart_d = sstart_q - nph_shift_i;
      base_d   = sstart_q - nph_shift_i;
      inc_d    = inc_q + dph_inc_i;
    end else if (samp_adv_i) begin
      base_d   = base_q + inc_q;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      base_q   <= '0;
      inc_q    <= '0;
      sstart_q <= '0;
    end else if (srst_i) begin
      base_q   <= '0;
      inc_q    <= '0;
      sstart_q <= '0;
    end else begin
      base_q   <= base_d;
      inc_q    <= inc_d;
      sstart_q <= sstart_d;
    end
  end

  assign base_nxt_o = base_d;

endmodule

// File: rtl/mtx_phase_seq_mc.sv
// mtx_phase_seq_mc: runtime-configurable, channel-interleaved phase-word
// sequencer (stepped-frequency symbol frames) on an AXI-stream master.
//   clk, aresetn, srst  : clock, async active-low reset, sync clear
//   en                  : level run request
//   cfg_*               : frame config, latched on IDLE->RUN
//   out_t*              : phase word, channel index (tuser), symbol/frame end
//   sync_ready          : frame counter is zero
//   busy                : sequencer not idle
// Optional: define MTX_PHASE_DITHER_EN to add a 4-bit LFSR dither to out_tdata.
module mtx_phase_seq_mc
  import mtx_seq_pkg::*;
#(
  parameter  int PHASE_WIDTH  = 24,
  parameter  int NSIG_WIDTH   = 24,
  parameter  int NSYMB_WIDTH  = 16,
  parameter  int NCH          = 2,
  parameter  int TX_SYNC_BITS = 2,
  localparam int CH_WIDTH     = ch_width(NCH)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   srst,
  input  logic                   en,
  input  logic [NSIG_WIDTH-1:0]  cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
  input  logic [PHASE_WIDTH-1:0] cfg_start_ph,
  input  logic [PHASE_WIDTH-1:0] cfg_start_ph_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_nph_shift,
  input  logic [PHASE_WIDTH-1:0] cfg_ch_ph_step,
  output logic [PHASE_WIDTH-1:0] out_tdata,
  output logic [CH_WIDTH-1:0]    out_tuser,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic                   out_tlast,
  output logic                   out_teof,
  output logic                   sync_ready,
  output logic                   busy
);

  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NCH - 1);

  state_e                  state_q, state_d;
  logic [NSIG_WIDTH-1:0]   nsig_q, nsig_d, sample_q, sample_d;
  logic [NSYMB_WIDTH-1:0]  nsymb_q, nsymb_d, symb_q, symb_d;
  logic [PHASE_WIDTH-1:0]  start_ph_q, start_inc_q, dph_q, nph_q, step_q;
  logic [CH_WIDTH-1:0]     ch_q, ch_d;
  logic [PHASE_WIDTH-1:0]  ch_off_q, ch_off_d;
  logic [TX_SYNC_BITS-1:0] frame_q, frame_d;
  logic                    load, adv, samp_adv, symb_adv, frame_adv;
  logic                    hs, tlast_d, teof_d;
  logic [PHASE_WIDTH-1:0]  base_nxt, dither;
  logic [PHASE_WIDTH-1:0]  tdata_q;
  logic [CH_WIDTH-1:0]     tuser_q;
  logic                    tvalid_q, tlast_q, teof_q;

  assign hs = tvalid_q & out_tready;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    symb_d    = symb_q;
    ch_d      = ch_q;
    ch_off_d  = ch_off_q;
    frame_d   = frame_q;
    load      = 1'b0;
    adv       = 1'b0;
    samp_adv  = 1'b0;
    symb_adv  = 1'b0;
    frame_adv = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: begin
        adv = hs;
        // Stopping is symbol-aligned: finish the symbol in STOP unless the
        // word leaving right now already closes it.
        if (!en) state_d = (hs && tlast_q) ? IDLE : STOP;
      end
      STOP: begin
        adv = hs;
        if (hs && tlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sample_d = NSIG_WIDTH'(1);
      symb_d   = NSYMB_WIDTH'(1);
      ch_d     = '0;
      ch_off_d = '0;
    end else if (adv) begin
      if (ch_q != LAST_CH) begin
        ch_d     = ch_q + 1'b1;
        ch_off_d = ch_off_q + step_q;
      end else begin
        ch_d     = '0;
        ch_off_d = '0;
        if (sample_q != nsig_q) begin
          sample_d = sample_q + 1'b1;
          samp_adv = 1'b1;
        end else begin
          sample_d = NSIG_WIDTH'(1);
          if (symb_q != nsymb_q) begin
            symb_d   = symb_q + 1'b1;
            symb_adv = 1'b1;
          end else begin
            symb_d    = NSYMB_WIDTH'(1);
            frame_adv = 1'b1;
            frame_d   = frame_q + 1'b1;
          end
        end
      end
    end
  end

  // Zero lengths are treated as one.
  assign nsig_d  = load ? ((cfg_nsig == '0) ? NSIG_WIDTH'(1) : cfg_nsig) : nsig_q;
  assign nsymb_d = load ? ((cfg_nsymb == '0) ? NSYMB_WIDTH'(1) : cfg_nsymb) : nsymb_q;

  // Flags describe the word that will be presented next cycle.
  assign tlast_d = (sample_d == nsig_d) && (ch_d == LAST_CH);
  assign teof_d  = tlast_d && (symb_d == nsymb_d);

  mtx_phase_acc #(.PW(PHASE_WIDTH)) u_acc (
    .clk_i       (clk),
    .aresetn_i   (aresetn),
    .srst_i      (srst),
    .load_i      (load),
    .samp_adv_i  (samp_adv),
    .symb_adv_i  (symb_adv),
    .frame_adv_i (frame_adv),
    .start_ph_i  (load ? cfg_start_ph : start_ph_q),
    .start_inc_i (load ? cfg_start_ph_inc : start_inc_q),
    .dph_inc_i   (dph_q),
    .nph_shift_i (nph_q),
    .base_nxt_o  (base_nxt)
  );

`ifdef MTX_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = adv ? lfsr_step(lfsr_q) : lfsr_q;
  // The nibble rides with the word it is added to, so it uses the value the
  // LFSR holds while that word is on the bus.
  assign dither = PHASE_WIDTH'(lfsr_d[3:0]);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)  lfsr_q <= LFSR_SEED;
    else if (srst) lfsr_q <= LFSR_SEED;
    else           lfsr_q <= lfsr_d;
  end
`else
  assign dither = '0;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      nsig_q <= '0; nsymb_q <= '0; sample_q <= '0; symb_q <= '0;
      start_ph_q <= '0; start_inc_q <= '0; dph_q <= '0; nph_q <= '0; step_q <= '0;
      ch_q <= '0; ch_off_q <= '0; frame_q <= '0;
      tdata_q <= '0; tuser_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0; teof_q <= 1'b0;
    end else if (srst) begin
      state_q <= IDLE;
      nsig_q <= '0; nsymb_q <= '0; sample_q <= '0; symb_q <= '0;
      start_ph_q <= '0; start_inc_q <= '0; dph_q <= '0; nph_q <= '0; step_q <= '0;
      ch_q <= '0; ch_off_q <= '0; frame_q <= '0;
      tdata_q <= '0; tuser_q <= '0; tvalid_q <= 1'b0; tlast_q <= 1'b0; teof_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nsig_q   <= nsig_d;
      nsymb_q  <= nsymb_d;
      sample_q <= sample_d;
      symb_q   <= symb_d;
      ch_q     <= ch_d;
      ch_off_q <= ch_off_d;
      frame_q  <= frame_d;
      if (load) begin
        start_ph_q  <= cfg_start_ph;
        start_inc_q <= cfg_start_ph_inc;
        dph_q       <= cfg_dph_inc;
        nph_q       <= cfg_nph_shift;
        step_q      <= cfg_ch_ph_step;
      end
      tvalid_q <= (state_d != IDLE);
      if (load || adv) begin
        tdata_q <= base_nxt + ch_off_d + dither;
        tuser_q <= ch_d;
        tlast_q <= tlast_d;
        teof_q  <= teof_d;
      end
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tuser  = tuser_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign out_teof   = teof_q;
  assign sync_ready = (frame_q == '0);
  assign busy       = (state_q != IDLE);

endmodule
